// File: rtl/cve2_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between the
// core mult/div path and the MAC sequencer.
module cve2_mul_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             core_req_i,
   input  logic [1:0]       core_op_i,
   input  logic [WIDTH-1:0] core_a_i,
   input  logic [WIDTH-1:0] core_b_i,
   output logic             core_gnt_o,
   output logic             core_rvalid_o,
   output logic             core_err_o,
   input  logic             mac_req_i,
   input  logic [1:0]       mac_op_i,
   input  logic [WIDTH-1:0] mac_a_i,
   input  logic [WIDTH-1:0] mac_b_i,
   output logic             mac_gnt_o,
   output logic             mac_rvalid_o,
   output logic             mac_err_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic             mul_start_o,
   output logic [1:0]       mul_op_o,
   output logic [WIDTH-1:0] mul_a_o,
   output logic [WIDTH-1:0] mul_b_o,
   input  logic             mul_done_i,
   input  logic [WIDTH-1:0] mul_result_i,
   output logic             busy_o,
   output logic             owner_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_e           state_q;
   logic             owner_q;
   logic             prio_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             err_q;
   logic [CW-1:0]    cnt_q;

   logic idle;
   logic any_req;
   logic pick_mac;
   logic resp;

   // mac wins when alone, or when both ask and it holds priority
   assign idle     = (state_q == IDLE) && !rst_i;
   assign any_req  = core_req_i | mac_req_i;
   assign pick_mac = mac_req_i & (~core_req_i | prio_q);

   assign core_gnt_o = idle & core_req_i & ~pick_mac;
   assign mac_gnt_o  = idle & pick_mac;

   assign resp          = (state_q == RESP);
   assign core_rvalid_o = resp & ~owner_q;
   assign mac_rvalid_o  = resp & owner_q;
   assign core_err_o    = resp & ~owner_q & err_q;
   assign mac_err_o     = resp & owner_q & err_q;

   assign rdata_o     = res_q;
   assign mul_start_o = (state_q == ISSUE);
   assign mul_op_o    = op_q;
   assign mul_a_o     = a_q;
   assign mul_b_o     = b_q;
   assign busy_o      = (state_q != IDLE);
   assign owner_o     = owner_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q <= pick_mac;
                  prio_q  <= ~pick_mac;
                  op_q    <= pick_mac ? mac_op_i : core_op_i;
                  a_q     <= pick_mac ? mac_a_i : core_a_i;
                  b_q     <= pick_mac ? mac_b_i : core_b_i;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (mul_done_i) begin
                  res_q   <= mul_result_i;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else begin
                  cnt_q   <= CW'(1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (mul_done_i) begin
                  res_q   <= mul_result_i;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (cnt_q == CW'(TIMEOUT)) begin
                  res_q   <= '0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(core_gnt_o && mac_gnt_o));
         assert (!mul_start_o || state_q == ISSUE);
         assert (!(core_rvalid_o || mac_rvalid_o) || state_q == RESP);
      end
   end

endmodule

// File: tb/tb_cve2_mul_arbiter.sv
// Directed-vector bench for cve2_mul_arbiter; the multiplier is played
// by the stimulus sequence itself.
module tb_cve2_mul_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i, mac_req_i;
   logic [1:0]  core_op_i, mac_op_i;
   logic [31:0] core_a_i, core_b_i, mac_a_i, mac_b_i;
   logic        core_gnt_o, core_rvalid_o, core_err_o;
   logic        mac_gnt_o, mac_rvalid_o, mac_err_o;
   logic [31:0] rdata_o;
   logic        mul_start_o;
   logic [1:0]  mul_op_o;
   logic [31:0] mul_a_o, mul_b_o;
   logic        mul_done_i;
   logic [31:0] mul_result_i;
   logic        busy_o, owner_o;

   int nvec = 0;
   int nerr = 0;

   cve2_mul_arbiter #(.WIDTH(32), .TIMEOUT(64)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_op_i(core_op_i),
      .core_a_i(core_a_i), .core_b_i(core_b_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
      .core_err_o(core_err_o),
      .mac_req_i(mac_req_i), .mac_op_i(mac_op_i),
      .mac_a_i(mac_a_i), .mac_b_i(mac_b_i),
      .mac_gnt_o(mac_gnt_o), .mac_rvalid_o(mac_rvalid_o),
      .mac_err_o(mac_err_o),
      .rdata_o(rdata_o), .mul_start_o(mul_start_o),
      .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
      .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_mac_quiet(input string tag);
      chk({tag, "_mgnt"}, {31'b0, mac_gnt_o}, 32'd0);
      chk({tag, "_mrv"}, {31'b0, mac_rvalid_o | mac_err_o}, 32'd0);
   endtask

   logic [31:0] ca, cb, ma, mb;
   logic        early;

   initial begin
      rst_i = 1'b1;
      core_req_i = 0; mac_req_i = 0;
      core_op_i = 0; mac_op_i = 0;
      core_a_i = 0; core_b_i = 0; mac_a_i = 0; mac_b_i = 0;
      mul_done_i = 0; mul_result_i = 0;
      tick(); tick();
      rst_i = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy_o}, 0);
      chk("rst_start", {31'b0, mul_start_o}, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_owner", {31'b0, owner_o}, 0);
      chk("rst_rv", {30'b0, core_rvalid_o, mac_rvalid_o}, 0);

      // core alone, 7*6, done 3 cycles after start
      core_req_i = 1; core_op_i = 2'd0; core_a_i = 7; core_b_i = 6;
      #1;
      chk("s1_gnt", {31'b0, core_gnt_o}, 1);
      chk_mac_quiet("s1_n");
      tick();
      chk("s1_start", {31'b0, mul_start_o}, 1);
      chk("s1_a", mul_a_o, 7);
      chk("s1_b", mul_b_o, 6);
      chk("s1_gnt1", {31'b0, core_gnt_o}, 0);
      tick();
      chk("s1_start2", {31'b0, mul_start_o}, 0);
      chk_mac_quiet("s1_n2");
      tick();
      tick();
      mul_done_i = 1; mul_result_i = 42;
      #1;
      chk("s1_rv4", {31'b0, core_rvalid_o}, 0);
      tick();
      mul_done_i = 0; core_req_i = 0;
      #1;
      chk("s1_rv", {31'b0, core_rvalid_o}, 1);
      chk("s1_rdata", rdata_o, 42);
      chk("s1_err", {31'b0, core_err_o}, 0);
      chk_mac_quiet("s1_n5");
      tick();
      chk("s1_busy", {31'b0, busy_o}, 0);
      chk("s1_rv6", {31'b0, core_rvalid_o}, 0);

      // both requesting continuously after reset
      rst_i = 1; tick(); rst_i = 0;
      ca = 3; cb = 5; ma = 10; mb = 11;
      core_req_i = 1; core_a_i = ca; core_b_i = cb;
      mac_req_i = 1; mac_a_i = ma; mac_b_i = mb; mac_op_i = 2'd1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_cgnt", {31'b0, core_gnt_o}, {31'b0, ~i[0]});
         chk("rr_mgnt", {31'b0, mac_gnt_o}, {31'b0, i[0]});
         tick();
         chk("rr_a", mul_a_o, i[0] ? ma : ca);
         tick();
         mul_done_i = 1; mul_result_i = i[0] ? ma * mb : ca * cb;
         tick();
         mul_done_i = 0;
         if (i == 3) begin
            core_req_i = 0; mac_req_i = 0;
         end
         #1;
         chk("rr_crv", {31'b0, core_rvalid_o}, {31'b0, ~i[0]});
         chk("rr_mrv", {31'b0, mac_rvalid_o}, {31'b0, i[0]});
         chk("rr_owner", {31'b0, owner_o}, {31'b0, i[0]});
         chk("rr_rdata", rdata_o, i[0] ? 32'd110 : 32'd15);
         tick();
      end

      // done in the ISSUE cycle
      core_req_i = 1; core_a_i = 9; core_b_i = 9;
      #1;
      chk("s3_gnt", {31'b0, core_gnt_o}, 1);
      tick();
      mul_done_i = 1; mul_result_i = 32'hFFFF_FFFF;
      #1;
      chk("s3_start", {31'b0, mul_start_o}, 1);
      tick();
      mul_done_i = 0; core_req_i = 0;
      #1;
      chk("s3_rv", {31'b0, core_rvalid_o}, 1);
      chk("s3_rdata", rdata_o, 32'hFFFF_FFFF);
      tick();

      // multiplier never answers
      core_req_i = 1; core_a_i = 2; core_b_i = 3;
      #1;
      chk("s4_gnt", {31'b0, core_gnt_o}, 1);
      early = 0;
      for (int k = 1; k <= 65; k++) begin
         tick();
         early |= core_rvalid_o | mac_rvalid_o;
      end
      chk("s4_early", {31'b0, early}, 0);
      tick();
      core_req_i = 0;
      #1;
      chk("s4_rv", {31'b0, core_rvalid_o}, 1);
      chk("s4_err", {31'b0, core_err_o}, 1);
      chk("s4_rdata", rdata_o, 0);
      chk_mac_quiet("s4_n");
      tick();
      chk("s4_busy", {31'b0, busy_o}, 0);

      // reset during WAIT, then stray done
      core_req_i = 1; core_a_i = 4; core_b_i = 4;
      #1;
      chk("s5_gnt", {31'b0, core_gnt_o}, 1);
      tick();
      tick();
      rst_i = 1; core_req_i = 0;
      tick();
      rst_i = 0; mul_done_i = 1; mul_result_i = 123;
      #1;
      chk("s5_busy", {31'b0, busy_o}, 0);
      chk("s5_start", {31'b0, mul_start_o}, 0);
      chk("s5_rdata", rdata_o, 0);
      chk("s5_mula", mul_a_o, 0);
      chk("s5_owner", {31'b0, owner_o}, 0);
      chk("s5_rv", {30'b0, core_rvalid_o, mac_rvalid_o}, 0);
      tick();
      mul_done_i = 0;
      #1;
      chk("s5_rv2", {30'b0, core_rvalid_o, mac_rvalid_o}, 0);
      chk("s5_rdata2", rdata_o, 0);
      core_req_i = 1; core_a_i = 2; core_b_i = 8;
      mac_req_i = 1; mac_a_i = 5; mac_b_i = 5;
      #1;
      chk("s5_cgnt", {31'b0, core_gnt_o}, 1);
      chk("s5_mgnt", {31'b0, mac_gnt_o}, 0);
      tick();
      mul_done_i = 1; mul_result_i = 16;
      tick();
      mul_done_i = 0; core_req_i = 0; mac_req_i = 0;
      #1;
      chk("s5_crv", {31'b0, core_rvalid_o}, 1);
      chk("s5_res", rdata_o, 16);
      tick();

      // mac drops req and changes operands after grant
      ma = 32'h1234; mb = 32'h100;
      mac_req_i = 1; mac_op_i = 2'd2; mac_a_i = ma; mac_b_i = mb;
      #1;
      chk("s6_gnt", {31'b0, mac_gnt_o}, 1);
      chk("s6_cgnt", {31'b0, core_gnt_o}, 0);
      tick();
      mac_req_i = 0; mac_a_i = 32'hDEAD; mac_b_i = 32'hBEEF;
      mac_op_i = 2'd3;
      #1;
      chk("s6_a", mul_a_o, 32'h1234);
      chk("s6_b", mul_b_o, 32'h100);
      chk("s6_op", {30'b0, mul_op_o}, 2);
      tick();
      chk("s6_a2", mul_a_o, 32'h1234);
      chk("s6_b2", mul_b_o, 32'h100);
      tick();
      mul_done_i = 1; mul_result_i = ma * mb;
      tick();
      mul_done_i = 0;
      #1;
      chk("s6_rv", {31'b0, mac_rvalid_o}, 1);
      chk("s6_rdata", rdata_o, 32'h0012_3400);
      chk("s6_crv", {31'b0, core_rvalid_o}, 0);
      chk("s6_owner", {31'b0, owner_o}, 1);
      tick();
      chk("s6_busy", {31'b0, busy_o}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
